// File: rtl/ext_trig_pkg.sv
// Shared types and default widths for the external-trigger run controller.
package ext_trig_pkg;

  localparam int DEAD_W  = 16;
  localparam int CNT_W   = 32;
  localparam int PHASE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2,
    DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/ext_trig_sat_counter.sv
// Saturating statistics counter: synchronous clear, sticks at all-ones.
module ext_trig_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear has priority over increment; increment stops at all-ones
  always_ff @(posedge clk) begin
    if (!resetn)                        count <= '0;
    else if (clr)                       count <= '0;
    else if (inc && (count != '1))      count <= count + W'(1);
  end

endmodule

// File: rtl/ext_trig_run_ctrl.sv
// Run/acceptance controller for the external-trigger path (clk40 domain).
// Optional build macro EXT_TRIG_PRESCALE_EN adds an input prescaler that
// accepts only every (prescale+1)-th otherwise-eligible candidate.
module ext_trig_run_ctrl #(
  parameter int DEAD_W  = ext_trig_pkg::DEAD_W,
  parameter int CNT_W   = ext_trig_pkg::CNT_W,
  parameter int PHASE_W = ext_trig_pkg::PHASE_W
) (
  input  logic               clk40,
  input  logic               resetn,
  input  logic               start_run,
  input  logic               stop_run,
  input  logic               candidate,
  input  logic [PHASE_W-1:0] candidate_phase,
  input  logic               busy_in,
  input  logic [DEAD_W-1:0]  dead_cycles,
  input  logic [CNT_W-1:0]   max_triggers,
`ifdef EXT_TRIG_PRESCALE_EN
  input  logic [7:0]         prescale,
`endif
  output logic               trig_out,
  output logic [PHASE_W-1:0] trig_phase,
  output logic               running,
  output logic [1:0]         run_state,
  output logic [CNT_W-1:0]   accepted_count,
  output logic [CNT_W-1:0]   busy_veto_count,
  output logic [CNT_W-1:0]   dead_veto_count
);

  import ext_trig_pkg::*;

  run_state_t        state, state_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;
  logic              busy_m, busy_s;
  logic              accept, busy_inc, dead_inc, clr;
  logic              ps_hit;
  logic [CNT_W-1:0]  acc_plus1;

  assign acc_plus1 = accepted_count + CNT_W'(1);
  assign running   = (state == RUN) || (state == DEAD);
  assign run_state = state;

  // two-flop synchroniser for the asynchronous downstream busy
  always_ff @(posedge clk40) begin
    if (!resetn) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= busy_in;
      busy_s <= busy_m;
    end
  end

`ifdef EXT_TRIG_PRESCALE_EN
  logic [7:0] ps_cnt;
  logic       eligible;

  assign eligible = (state == RUN) && !stop_run && candidate && !busy_s;
  assign ps_hit   = (ps_cnt == prescale);

  // prescale counter advances on every eligible candidate, restarts each run
  always_ff @(posedge clk40) begin
    if (!resetn || clr)  ps_cnt <= '0;
    else if (eligible)   ps_cnt <= ps_hit ? 8'd0 : ps_cnt + 8'd1;
  end
`else
  assign ps_hit = 1'b1;
`endif

  // next state, deadtime reload and the per-cycle accept/veto decisions
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    accept    = 1'b0;
    busy_inc  = 1'b0;
    dead_inc  = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start_run && !stop_run) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        if (stop_run) state_nxt = IDLE;
        else if (candidate) begin
          if (busy_s) busy_inc = 1'b1;
          else if (ps_hit) begin
            accept = 1'b1;
            // reaching the limit wins over starting a deadtime
            if ((max_triggers != '0) && (acc_plus1 == max_triggers)) state_nxt = DONE;
            else if (dead_cycles != '0) begin
              state_nxt = DEAD;
              dead_nxt  = dead_cycles;
            end
          end
        end
      end
      DEAD: begin
        if (stop_run) state_nxt = IDLE;
        else begin
          dead_inc = candidate;
          dead_nxt = dead_cnt - DEAD_W'(1);
          if (dead_cnt == DEAD_W'(1)) state_nxt = RUN;
        end
      end
      DONE: begin
        if (stop_run) state_nxt = IDLE;
        else if (start_run) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, deadtime counter and the registered trigger outputs
  always_ff @(posedge clk40) begin
    if (!resetn) begin
      state      <= IDLE;
      dead_cnt   <= '0;
      trig_out   <= 1'b0;
      trig_phase <= '0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      trig_out <= accept;
      if (accept) trig_phase <= candidate_phase;
    end
  end

  ext_trig_sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk(clk40), .resetn(resetn), .clr(clr), .inc(accept), .count(accepted_count)
  );

  ext_trig_sat_counter #(.W(CNT_W)) u_busy_cnt (
    .clk(clk40), .resetn(resetn), .clr(clr), .inc(busy_inc), .count(busy_veto_count)
  );

  ext_trig_sat_counter #(.W(CNT_W)) u_dead_cnt (
    .clk(clk40), .resetn(resetn), .clr(clr), .inc(dead_inc), .count(dead_veto_count)
  );

endmodule

// File: tb/tb_ext_trig_run_ctrl.sv
// Scoreboard bench for ext_trig_run_ctrl; honours EXT_TRIG_PRESCALE_EN.
module tb_ext_trig_run_ctrl;

  logic        clk40 = 1'b0;
  logic        resetn, start_run, stop_run, candidate, busy_in;
  logic [4:0]  candidate_phase;
  logic [15:0] dead_cycles;
  logic [31:0] max_triggers;
`ifdef EXT_TRIG_PRESCALE_EN
  logic [7:0]  prescale;
`endif
  logic        trig_out, running;
  logic [4:0]  trig_phase;
  logic [1:0]  run_state;
  logic [31:0] accepted_count, busy_veto_count, dead_veto_count;

  ext_trig_run_ctrl dut (
    .clk40(clk40), .resetn(resetn), .start_run(start_run), .stop_run(stop_run),
    .candidate(candidate), .candidate_phase(candidate_phase), .busy_in(busy_in),
    .dead_cycles(dead_cycles), .max_triggers(max_triggers),
`ifdef EXT_TRIG_PRESCALE_EN
    .prescale(prescale),
`endif
    .trig_out(trig_out), .trig_phase(trig_phase), .running(running),
    .run_state(run_state), .accepted_count(accepted_count),
    .busy_veto_count(busy_veto_count), .dead_veto_count(dead_veto_count)
  );

  always #5 clk40 = ~clk40;

  int cyc = 0;
  always @(posedge clk40) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] ph; } trig_t;
  typedef struct {
    int cyc; logic [1:0] rs; logic run;
    logic [31:0] acc, bv, dv; logic [4:0] ph;
  } st_t;

  trig_t tq[$];
  st_t   sq[$];
  int    errors = 0;
  int    checks = 0;
  logic  done = 1'b0;

  task automatic step();
    @(posedge clk40); #1;
  endtask

  // pulse expected in the cycle after the candidate driven now
  task automatic expect_trig(input logic [4:0] ph);
    trig_t t;
    t.cyc = cyc + 1; t.ph = ph;
    tq.push_back(t);
  endtask

  // status expected in the current cycle
  task automatic expect_state(input logic [1:0] rs, input logic run,
                              input logic [31:0] acc, input logic [31:0] bv,
                              input logic [31:0] dv, input logic [4:0] ph);
    st_t s;
    s.cyc = cyc; s.rs = rs; s.run = run; s.acc = acc; s.bv = bv; s.dv = dv; s.ph = ph;
    sq.push_back(s);
  endtask

  // monitor: compares DUT outputs against queued expectations
  initial begin
    trig_t e;
    st_t   s;
    forever begin
      @(negedge clk40);
      if (cyc >= 2) begin
        if (trig_out) begin
          checks++;
          if (tq.size() == 0) begin
            errors++;
            $display("FAIL trig_unexpected cyc=%0d phase=%0d", cyc, trig_phase);
          end else begin
            e = tq.pop_front();
            if (e.cyc != cyc || e.ph !== trig_phase) begin
              errors++;
              $display("FAIL trig_pulse got cyc=%0d phase=%0d want cyc=%0d phase=%0d",
                       cyc, trig_phase, e.cyc, e.ph);
            end
          end
        end else if (tq.size() != 0 && tq[0].cyc <= cyc) begin
          checks++; errors++;
          e = tq.pop_front();
          $display("FAIL trig_missing cyc=%0d want phase=%0d", e.cyc, e.ph);
        end
        while (sq.size() != 0 && sq[0].cyc <= cyc) begin
          s = sq.pop_front();
          checks++;
          if (s.cyc != cyc || run_state !== s.rs || running !== s.run ||
              accepted_count !== s.acc || busy_veto_count !== s.bv ||
              dead_veto_count !== s.dv || trig_phase !== s.ph) begin
            errors++;
            $display("FAIL status cyc=%0d got st=%0d run=%0d acc=%0d bv=%0d dv=%0d ph=%0d want st=%0d run=%0d acc=%0d bv=%0d dv=%0d ph=%0d",
                     cyc, run_state, running, accepted_count, busy_veto_count,
                     dead_veto_count, trig_phase, s.rs, s.run, s.acc, s.bv, s.dv, s.ph);
          end
        end
      end
      if (done) begin
        checks++;
        if (tq.size() != 0 || sq.size() != 0) begin
          errors++;
          $display("FAIL leftover trig=%0d status=%0d want 0 0", tq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (cyc > 3000) begin
        errors++;
        $display("FAIL timeout cyc=%0d limit=3000", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // directed stimulus
  initial begin
    resetn = 1'b0; start_run = 1'b0; stop_run = 1'b0; candidate = 1'b0;
    candidate_phase = '0; busy_in = 1'b0; dead_cycles = '0; max_triggers = '0;
`ifdef EXT_TRIG_PRESCALE_EN
    prescale = '0;
`endif
    step(); step();
    expect_state(0, 0, 0, 0, 0, 0);
    resetn = 1'b1; step();

    // back-to-back accepts with no deadtime
    start_run = 1'b1; step(); start_run = 1'b0;
    expect_state(1, 1, 0, 0, 0, 0);
    expect_trig(3); candidate = 1'b1; candidate_phase = 5'd3; step();
    expect_trig(4); candidate_phase = 5'd4; step();
    candidate = 1'b0; step();
    expect_state(1, 1, 2, 0, 0, 4);

    // deadtime of 4: veto at t+2, eligible again at t+5
    dead_cycles = 16'd4;
    expect_trig(5); candidate = 1'b1; candidate_phase = 5'd5; step();
    candidate = 1'b0; step();
    candidate = 1'b1; candidate_phase = 5'd6; step();
    candidate = 1'b0; step(); step();
    expect_trig(7); candidate = 1'b1; candidate_phase = 5'd7; step();
    candidate = 1'b0;
    expect_state(2, 1, 4, 0, 1, 7);
    dead_cycles = 16'd0;
    repeat (5) step();
    expect_state(1, 1, 4, 0, 1, 7);

    // busy three cycles ahead vetoes; one cycle ahead is too late to veto
    busy_in = 1'b1; step(); step(); step();
    candidate = 1'b1; candidate_phase = 5'd8; step();
    candidate = 1'b0; busy_in = 1'b0; step(); step(); step();
    expect_state(1, 1, 4, 1, 1, 7);
    busy_in = 1'b1; step();
    expect_trig(9); candidate = 1'b1; candidate_phase = 5'd9; step();
    candidate = 1'b0; busy_in = 1'b0; step(); step(); step();
    expect_state(1, 1, 5, 1, 1, 9);

    // stop holds counters, restart clears, trigger limit of 3
    stop_run = 1'b1; step(); stop_run = 1'b0;
    expect_state(0, 0, 5, 1, 1, 9);
    start_run = 1'b1; step(); start_run = 1'b0;
    expect_state(1, 1, 0, 0, 0, 9);
    max_triggers = 32'd3;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) expect_trig(5'(10 + i));
      candidate = 1'b1; candidate_phase = 5'(10 + i); step();
    end
    candidate = 1'b0;
    expect_state(3, 0, 3, 0, 0, 12);
    start_run = 1'b1; step(); start_run = 1'b0;
    expect_state(1, 1, 0, 0, 0, 12);
    max_triggers = 32'd0;

    // stop coincident with candidate; start+stop in IDLE; IDLE ignores candidates
    stop_run = 1'b1; candidate = 1'b1; candidate_phase = 5'd15; step();
    stop_run = 1'b0; candidate = 1'b0;
    expect_state(0, 0, 0, 0, 0, 12);
    start_run = 1'b1; stop_run = 1'b1; step();
    start_run = 1'b0; stop_run = 1'b0;
    expect_state(0, 0, 0, 0, 0, 12);
    candidate = 1'b1; candidate_phase = 5'd16; step(); candidate = 1'b0;
    expect_state(0, 0, 0, 0, 0, 12);

    // reset during DEAD, then reset on an accepting edge suppresses the pulse
    start_run = 1'b1; step(); start_run = 1'b0;
    dead_cycles = 16'd5;
    expect_trig(17); candidate = 1'b1; candidate_phase = 5'd17; step();
    candidate_phase = 5'd18; step();
    candidate = 1'b0;
    expect_state(2, 1, 1, 0, 1, 17);
    resetn = 1'b0; step(); resetn = 1'b1;
    expect_state(0, 0, 0, 0, 0, 0);
    dead_cycles = 16'd0;
    start_run = 1'b1; step(); start_run = 1'b0;
    candidate = 1'b1; candidate_phase = 5'd19; resetn = 1'b0; step();
    candidate = 1'b0; resetn = 1'b1;
    expect_state(0, 0, 0, 0, 0, 0);
    step();

`ifdef EXT_TRIG_PRESCALE_EN
    // prescale=2: accept the 3rd, 6th and 9th eligible candidates
    prescale = 8'd2;
    start_run = 1'b1; step(); start_run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 2) expect_trig(5'(20 + i));
      candidate = 1'b1; candidate_phase = 5'(20 + i); step();
    end
    candidate = 1'b0;
    expect_state(1, 1, 3, 0, 0, 28);
`endif

    step(); step(); step();
    done = 1'b1;
  end

endmodule

// File: doc/ext_trig_run_ctrl.md
Name: ext_trig_run_ctrl

Overview:
Run and acceptance controller for the external-trigger path in the clk40 domain.
- Takes per-bunch trigger candidates from the phase finder.
- Applies the run gate, a synchronised busy veto, a programmable deadtime and a trigger-count limit.
- Emits a one-cycle accepted-trigger pulse with the latched phase.
- Exposes run state and veto statistics to the IPIF register block.

Parameters:
DEAD_W, 16, width of deadtime length in clk40 cycles
CNT_W, 32, width of statistics counters and trigger limit
PHASE_W, 5, width of candidate/trigger phase

Ports:
clk40  in  1  sole clock, 40 MHz
resetn  in  1  reset, synchronous, active-low
start_run  in  1  one-cycle start request (ORed bus/external upstream)
stop_run  in  1  one-cycle stop request
candidate  in  1  trigger candidate valid, one cycle per candidate
candidate_phase  in  PHASE_W  sub-bunch phase of candidate
busy_in  in  1  asynchronous busy from downstream
dead_cycles  in  DEAD_W  deadtime length after each accept
max_triggers  in  CNT_W  accept limit per run; 0 = unlimited
trig_out  out  1  registered accepted-trigger pulse
trig_phase  out  PHASE_W  phase of last accepted trigger, held until next accept
running  out  1  high in RUN or DEAD
run_state  out  2  IDLE=0, RUN=1, DEAD=2, DONE=3
accepted_count  out  CNT_W  accepts this run
busy_veto_count  out  CNT_W  candidates rejected by busy
dead_veto_count  out  CNT_W  candidates rejected by deadtime

Behaviour:
- Reset (resetn low at clk40 edge): state IDLE; all outputs, counters, deadtime counter and busy synchroniser are 0.
- busy_in passes through a 2-flop synchroniser (busy_s). A busy_in change first affects the veto 2 cycles later.
- IDLE:
  - start_run -> RUN; all three counters clear on the same edge.
  - start_run and stop_run together: stop wins, stay IDLE.
  - Candidates are ignored and not counted.
- RUN, candidate with busy_s=0 is an accept:
  - trig_out=1 on the next cycle (latency 1); trig_phase<=candidate_phase; accepted_count+1.
  - dead_cycles is sampled on the accept edge. If D=0, stay RUN (back-to-back accepts allowed). If D>0, go to DEAD with the counter loaded to D.
  - If max_triggers!=0 and accepted_count+1==max_triggers, go to DONE instead. DONE takes precedence over DEAD.
- RUN, candidate with busy_s=1: busy_veto_count+1, no trigger.
- DEAD: counter decrements each cycle.
  - Accept at cycle t gives DEAD during t+1..t+D and RUN at t+D+1; a candidate at t+D+1 is eligible.
  - Candidate in DEAD: dead_veto_count+1. Deadtime takes precedence over busy; only one counter increments.
- DONE: running=0; candidates ignored and not counted; counters held for readout.
  - start_run -> RUN with counters cleared.
  - stop_run -> IDLE.
- stop_run in RUN, DEAD or DONE -> IDLE on the next edge.
  - stop_run coincident with a candidate: no accept, no count.
  - Counters hold their values in IDLE.
- start_run while in RUN or DEAD is ignored; no clear.
- trig_out is strictly a one-cycle pulse; it is 0 in every cycle not following an accept.
- All counters saturate at all-ones and do not wrap.
- max_triggers is compared live. Lowering it below accepted_count mid-run does not force DONE; the run continues until stop_run.
- Reset mid-run: immediate IDLE, counters 0, any pending trig_out suppressed.

Optional Feature:
EXT_TRIG_PRESCALE_EN
- Defined: adds input port prescale [7:0].
  - Only every (prescale+1)-th otherwise-eligible candidate is accepted.
  - Skipped candidates are not counted, start no deadtime and do not advance toward DONE.
  - The prescale counter clears on run start.
- Undefined: port absent; every eligible candidate is accepted.

Decomposition:
- Package ext_trig_pkg:
  - run_state_t enum (IDLE, RUN, DEAD, DONE with the encodings above);
  - default widths DEAD_W, CNT_W, PHASE_W.
- Sub-module ext_trig_sat_counter: CNT_W saturating counter with clear and increment inputs, instantiated three times.

Test Plan:
- Reset, then start_run, then candidates at cycles 10 and 11, dead_cycles=0, busy low -> trig_out pulses at 11 and 12, accepted_count=2, run_state=1.
- dead_cycles=4, accept at t, candidates at t+2 and t+5 -> dead_veto_count=1, second accepted, trig_out at t+6, trig_phase = second candidate's phase.
- busy_in high 3 cycles before a candidate in RUN -> no trig_out, busy_veto_count=1; busy_in high 1 cycle before a candidate -> accepted (synchroniser latency).
- max_triggers=3, dead_cycles=0, 5 candidates -> 3 pulses, run_state=3, running=0, accepted_count=3; start_run -> counters 0, RUN.
- stop_run coincident with candidate in RUN -> no pulse, no counts, IDLE next cycle; start_run and stop_run together in IDLE -> stays IDLE.
- resetn low during DEAD with counters nonzero -> next cycle IDLE, all outputs 0; with EXT_TRIG_PRESCALE_EN and prescale=2, 9 eligible candidates -> 3 accepts.
